// File: rtl/fft16_sched.sv
// fft16_sched: sequencer for a 16-point radix-4 FFT that time-shares a single
// 4-input complex butterfly.
// The sequencer loads 16 samples into an in-place buffer. It issues two
// radix-4 stages of four butterfly operations each and writes every result
// back to the addresses its operands came from. It then streams the
// digit-reversed buffer out in natural order.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   sample input stream, in_data = {Re[16:0], Im[16:0]}
//   out_valid/out_ready spectrum output stream, out_data = {Re, Im}
//   frame_done          pulse on acceptance of the 16th output sample
//   busy                high from the first stage until the frame is unloaded
//   bf_rst_n            butterfly reset, ~rst
//   bf_calc_in          butterfly operands {in4, in3, in2, in1}
//   bf_rotation         butterfly rotation code
//   bf_calc_out         butterfly results, BF_LAT cycles after issue
module fft16_sched #(
  parameter int unsigned BF_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [33:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [33:0]  out_data,
  output logic         frame_done,
  output logic         busy,
  output logic         bf_rst_n,
  output logic [135:0] bf_calc_in,
  output logic [2:0]   bf_rotation,
  input  logic [135:0] bf_calc_out
);

  localparam int unsigned SW    = 34;
  localparam int unsigned NLANE = 4;
  localparam int unsigned NSAMP = 16;
  localparam int unsigned AW    = 4;

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    S1      = 3'd1,
    S1_WAIT = 3'd2,
    S2      = 3'd3,
    S2_WAIT = 3'd4,
    UNLOAD  = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;
  logic [1:0]    grp, grp_nxt;
  logic [SW-1:0] mem [NSAMP];

  // Writeback delay line: entry BF_LAT-1 holds the issue whose result is on
  // bf_calc_out this cycle.
  logic [BF_LAT-1:0] wb_vld;
  logic [BF_LAT-1:0] wb_s2;
  logic [AW-1:0]     wb_base [BF_LAT];

  logic          issue_c;
  logic          wb_drain_c;
  logic [AW-1:0] wb_addr_c [NLANE];

  assign bf_rst_n = ~rst;
  assign issue_c  = (state == S1) || (state == S2);

  // Drain = the last outstanding result is being written this cycle.
  // Lane k goes back to base + 4k in stage 1 and base + k in stage 2.
  always_comb begin : wb_ctl
    wb_drain_c = wb_vld[BF_LAT-1];
    for (int unsigned k = 0; k + 1 < BF_LAT; k++) begin
      if (wb_vld[k]) wb_drain_c = 1'b0;
    end
    for (int unsigned k = 0; k < NLANE; k++) begin
      wb_addr_c[k] = wb_s2[BF_LAT-1] ? wb_base[BF_LAT-1] + AW'(k)
                                     : wb_base[BF_LAT-1] + AW'(4 * k);
    end
  end

  // Next-state and output decode.
  always_comb begin : fsm_comb
    state_nxt   = state;
    idx_nxt     = idx;
    grp_nxt     = grp;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    frame_done  = 1'b0;
    busy        = 1'b1;
    bf_calc_in  = '0;
    bf_rotation = '0;
    case (state)
      LOAD: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) begin
          idx_nxt = idx + AW'(1);
          if (idx == AW'(NSAMP - 1)) state_nxt = S1;
        end
      end
      S1: begin
        bf_rotation = {1'b0, grp};
        bf_calc_in  = {mem[{2'd3, grp}], mem[{2'd2, grp}],
                       mem[{2'd1, grp}], mem[{2'd0, grp}]};
        grp_nxt     = grp + 2'd1;
        if (grp == 2'd3) state_nxt = S1_WAIT;
      end
      S1_WAIT: begin
        if (wb_drain_c) state_nxt = S2;
      end
      S2: begin
        bf_rotation = {1'b1, grp};
        bf_calc_in  = {mem[{grp, 2'd3}], mem[{grp, 2'd2}],
                       mem[{grp, 2'd1}], mem[{grp, 2'd0}]};
        grp_nxt     = grp + 2'd1;
        if (grp == 2'd3) state_nxt = S2_WAIT;
      end
      S2_WAIT: begin
        if (wb_drain_c) state_nxt = UNLOAD;
      end
      UNLOAD: begin
        out_valid = 1'b1;
        out_data  = mem[{idx[1:0], idx[3:2]}];
        if (out_ready) begin
          idx_nxt = idx + AW'(1);
          if (idx == AW'(NSAMP - 1)) begin
            frame_done = ~rst;
            state_nxt  = LOAD;
          end
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Control state and writeback valids; reset cancels pending writebacks.
  always_ff @(posedge clk) begin : ctl_regs
    if (rst) begin
      state  <= LOAD;
      idx    <= '0;
      grp    <= '0;
      wb_vld <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      grp       <= grp_nxt;
      wb_vld[0] <= issue_c;
      for (int unsigned k = 1; k < BF_LAT; k++) begin
        wb_vld[k] <= wb_vld[k-1];
      end
    end
  end

  // Writeback address tags travel alongside the valids.
  always_ff @(posedge clk) begin : wb_meta
    wb_s2[0]   <= (state == S2);
    wb_base[0] <= (state == S2) ? {grp, 2'b00} : {2'b00, grp};
    for (int unsigned k = 1; k < BF_LAT; k++) begin
      wb_s2[k]   <= wb_s2[k-1];
      wb_base[k] <= wb_base[k-1];
    end
  end

  // In-place sample buffer; loads and writebacks never coincide.
  always_ff @(posedge clk) begin : buf_wr
    if (in_ready && in_valid) mem[idx] <= in_data;
    if (wb_vld[BF_LAT-1]) begin
      for (int unsigned k = 0; k < NLANE; k++) begin
        mem[wb_addr_c[k]] <= bf_calc_out[k*SW +: SW];
      end
    end
  end

endmodule
